pulse_burst_gen: RTL
====================

# pulse_burst_gen

Synchronous, programmable pulse-burst generator. It is the stage directly downstream of the free-running `clock` generator: it consumes `clock` and derives a square-wave `signal` whose half-period is a whole number of clock cycles. It emits either a fixed number of pulses or a continuous train. A start/busy/done handshake lets a controller request bursts. It replaces delay-timed pulse modules with a clock-synchronous, resettable equivalent.

## Interface
- `HW`, default 8: width of the half-period setting.
- `CW`, default 8: width of the pulse-count setting and pulse counter.

Ports:
- `clock`, input, 1: single system clock; all state updates on its rising edge.
- `clear`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: burst request, sampled in IDLE only.
- `stop`, input, 1: abort request, sampled every cycle.
- `half`, input, HW: half-period in clock cycles; 0 is treated as 1.
- `count`, input, CW: number of pulses per burst; 0 means continuous until `stop`.
- `signal`, output, 1: generated pulse train, registered.
- `busy`, output, 1: high while a burst is in progress.
- `done`, output, 1: one-cycle strobe when a counted burst completes normally.
- `pulses`, output, CW: rising edges of `signal` emitted in the current or last burst.

## Operation
- States: IDLE, HIGH, LOW.
- On `clear` low, immediately and regardless of clock:
  - state = IDLE.
  - `signal`, `busy`, `done` = 0; `pulses` = 0.
  - internal timer and latched settings = 0.
- IDLE:
  - `signal` = 0, `busy` = 0.
  - `start` = 1 with `stop` = 0 at an edge: latch `half_r` = max(`half`,1) and `count_r` = `count`; go to HIGH; `pulses` = 1; load timer = `half_r`-1.
  - `start` with `stop` in the same cycle: remain in IDLE, nothing latched.
- HIGH:
  - `signal` = 1.
  - Timer ≠ 0: decrement.
  - Timer = 0: go to LOW and reload timer = `half_r`-1.
- LOW:
  - `signal` = 0.
  - Timer ≠ 0: decrement.
  - Timer = 0, and `count_r` = 0 or `pulses` ≠ `count_r`: go to HIGH, `pulses` += 1 (wraps modulo 2^CW), reload timer.
  - Timer = 0 and `count_r` ≠ 0 and `pulses` = `count_r`: go to IDLE, `done` = 1 for exactly one cycle.
- `stop` = 1 in HIGH or LOW: next state IDLE, `signal` = 0, `done` stays 0, `pulses` holds its value.
- `start` while busy is ignored. `half` and `count` changes while busy have no effect.
- `pulses` holds after a burst ends and is overwritten with 1 by the next accepted `start`.
- `busy` = 1 exactly when state ≠ IDLE.

## Timing
- Latency: `start` sampled at edge E0 → `signal` = 1, `busy` = 1, `pulses` = 1 valid after E0.
- Each pulse lasts `half_r` cycles high, then `half_r` cycles low. Period is 2·`half_r` cycles, duty is 50%.
- A counted burst occupies exactly 2·`half_r`·`count_r` cycles. `busy` falls and `done` rises at the same edge, E(2·`half_r`·`count_r`).
- `done` clears at the following edge. A `start` in the cycle where `done` = 1 is accepted, since the state is already IDLE.
- Continuous mode: `pulses` wraps 2^CW−1 → 0 → 1 with no glitch on `signal` and no `done`.
- `clear` asserted mid-burst: all outputs go to 0 asynchronously. After release, the block waits in IDLE for a new `start`.
- With `half` = 1, `signal` toggles every cycle, giving the maximum rate of clock/2.

## Test plan
- Reset: `clear` = 0 mid-run → `signal` = `busy` = `done` = 0 and `pulses` = 0 without waiting for a clock edge; after release, IDLE persists with `start` = 0.
- Counted burst: `half` = 3, `count` = 2, `start` at E0 → `signal` high E0–E3, low E3–E6, high E6–E9, low E9–E12; `pulses` = 1 then 2 at E6; `busy` drops and `done` = 1 at E12 for one cycle.
- Minimum half-period: `half` = 0, `count` = 4 → behaves as `half` = 1; `signal` toggles every cycle, burst lasts 8 cycles, `pulses` = 4, `done` at E8.
- Continuous mode with wrap: CW = 8, `half` = 1, `count` = 0 → `pulses` goes 255 → 0 → 1 and `signal` stays regular; `stop` at edge Ek → IDLE, `signal` = 0 after Ek, `done` never asserted.
- Handshake corners:
  - `start` held high throughout a burst → no restart until IDLE.
  - `start` in the `done` cycle → new burst begins at the next edge.
  - `start` and `stop` together in IDLE → no burst.
  - `half` and `count` changed mid-burst → burst timing unchanged.
- Abort mid-pulse: `half` = 5, `count` = 3, `stop` during the second HIGH → `signal` = 0 next cycle, `pulses` holds 2, `done` = 0.

Source files
------------

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: programmable square-wave burst generator with start/busy/done handshake.
// Ports:
//   clock  - system clock, all state changes on its rising edge
//   clear  - asynchronous active-low reset
//   start  - burst request, honoured only while idle
//   stop   - abort request, honoured every cycle while busy
//   half   - half-period in clock cycles (0 behaves as 1)
//   count  - pulses per burst (0 = run until stop)
//   signal - registered pulse train
//   busy   - high while a burst is running
//   done   - one-cycle strobe when a counted burst finishes normally
//   pulses - rising edges of signal in the current or most recent burst
module pulse_burst_gen #(
    parameter int HW = 8,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          start,
    input  logic          stop,
    input  logic [HW-1:0] half,
    input  logic [CW-1:0] count,
    output logic          signal,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pulses
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t state, state_nx;
    logic [HW-1:0] timer, half_r, half_eff;
    logic [CW-1:0] count_r;
    logic expired, last;
    assign half_eff = (half == '0) ? HW'(1) : half;
    assign expired  = timer == '0;
    // a counted burst ends once the final low phase has run out
    assign last     = count_r != '0 && pulses == count_r;
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (start && !stop) ? HIGH : IDLE;
            HIGH:    state_nx = stop ? IDLE : expired ? LOW : HIGH;
            LOW:     state_nx = stop ? IDLE : !expired ? LOW : last ? IDLE : HIGH;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy = state != IDLE;
    end
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            signal  <= 1'b0;
            done    <= 1'b0;
            pulses  <= '0;
            timer   <= '0;
            half_r  <= '0;
            count_r <= '0;
        end else begin
            // signal mirrors the upcoming state so it is a clean flop output
            signal <= state_nx == HIGH;
            done   <= state == LOW && expired && last && !stop;
            if (state == IDLE && state_nx == HIGH) begin
                half_r  <= half_eff;
                count_r <= count;
                pulses  <= CW'(1);
                timer   <= half_eff - HW'(1);
            end else if (state != IDLE) begin
                timer <= expired ? half_r - HW'(1) : timer - HW'(1);
            end
            if (state == LOW && state_nx == HIGH) pulses <= pulses + CW'(1);
        end
    end
endmodule
